// File: rtl/mips_defs.sv
// mips_defs: shared register-file constants for the MIPS core
package mips_defs;
    localparam int REG_ZERO = 0;
    localparam int REG_RA = 31;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_WIDTH = 32;
endpackage

// File: rtl/demux_onehot.sv
// demux_onehot: one-hot write-address decoder with the $zero slot masked off
module demux_onehot
    import mips_defs::*;
#(
    parameter int N = 32,
    parameter int AW = $clog2(N)
) (
    input  logic          en,
    input  logic [AW-1:0] addr,
    output logic [N-1:0]  sel
);
    always_comb begin
        sel = '0;
        for (int i = 0; i < N; i++) sel[i] = en && (addr == AW'(i)) && (i != REG_ZERO);
    end
endmodule

// File: rtl/grf_wdemux.sv
// grf_wdemux: 32-entry register file with demuxed write port, two read ports and optional bypass
module grf_wdemux
    import mips_defs::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [WIDTH-1:0]  rd1,
    output logic [WIDTH-1:0]  rd2,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [WIDTH-1:0]  wd,
    output logic              wr_fire,
    output logic [ADDR_W-1:0] wr_addr_q
);
    localparam int N = 2 ** ADDR_W;
    logic [N-1:0] sel;
    logic [WIDTH-1:0] regs_q [N-1:1];
    logic [WIDTH-1:0] regs_d [N-1:1];
    logic wr_fire_q, wr_fire_d;
    logic [ADDR_W-1:0] wr_addr_d;
    demux_onehot #(.N(N), .AW(ADDR_W)) u_dec (.en(we), .addr(wa), .sel(sel));
    // sel already excludes $zero, so sel[raN] is exactly the bypass hit condition
    always_comb begin
        regs_d = regs_q;
        for (int i = 1; i < N; i++) regs_d[i] = sel[i] ? wd : regs_q[i];
        wr_fire_d = |sel;
        wr_addr_d = wr_fire_d ? wa : wr_addr_q;
        rd1 = reset ? '0 : (BYPASS != 0 && sel[ra1]) ? wd : (ra1 == ADDR_W'(REG_ZERO)) ? '0 : regs_q[ra1];
        rd2 = reset ? '0 : (BYPASS != 0 && sel[ra2]) ? wd : (ra2 == ADDR_W'(REG_ZERO)) ? '0 : regs_q[ra2];
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < N; i++) regs_q[i] <= '0;
            wr_fire_q <= 1'b0;
            wr_addr_q <= '0;
        end else begin
            regs_q <= regs_d;
            wr_fire_q <= wr_fire_d;
            wr_addr_q <= wr_addr_d;
        end
    end
    assign wr_fire = wr_fire_q;
endmodule

// File: doc/grf_wdemux.md
Name: grf_wdemux

Overview:
- General register file for the MIPS core: 32 registers x WIDTH bits, one write port, two read ports.
- The write path is an address decoder/demultiplexer that steers write-back data into exactly one register. It is the inverse of the operand-select muxes on the datapath.
- Sits between the writeback-stage mux output and the decode-stage operand muxes.
- Provides optional same-cycle write-to-read bypass, so decode sees a value being written back in the same cycle.

Parameters:
- WIDTH, 32, data width of each register.
- ADDR_W, 5, register address width; register count = 2**ADDR_W.
- BYPASS, 1, 1 enables write-to-read forwarding inside the block; 0 disables it.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- ra1  input  ADDR_W  read address, port 1 (rs).
- ra2  input  ADDR_W  read address, port 2 (rt).
- rd1  output  WIDTH  read data, port 1.
- rd2  output  WIDTH  read data, port 2.
- we  input  1  write enable.
- wa  input  ADDR_W  write address (rd/rt/$31, chosen upstream).
- wd  input  WIDTH  write data.
- wr_fire  output  1  registered pulse: a write committed on the previous edge.
- wr_addr_q  output  ADDR_W  registered address of the last committed write.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on port reset.
- Reset assertion clears immediately, without waiting for clk:
  - all registers to 0
  - wr_fire to 0
  - wr_addr_q to 0
- While reset is high:
  - rd1 and rd2 are forced to 0.
  - Bypass is suppressed.
  - Writes are ignored, even if a clk edge occurs.
- Write decode: a one-hot vector sel[i] = we & (wa == i) & (i != 0).
  - On the rising edge of clk, register i loads wd when sel[i]=1. Every other register holds its value.
  - Exactly one register, or none, is written per cycle.
- Register 0 ($zero):
  - Never stored; reads of address 0 always return 0.
  - A write with wa=0 is a no-op: wr_fire stays 0 and wr_addr_q does not update.
- Read:
  - Combinational, zero latency: rd1 = R[ra1] and rd2 = R[ra2] from the current register state.
- Bypass, when BYPASS=1, we=1, wa!=0 and wa==raN:
  - rdN = wd in the same cycle, before the edge.
  - After the edge the stored value is visible; the result is identical either way.
  - Both ports may bypass at once when ra1==ra2==wa.
- Bypass disabled (BYPASS=0): reads return the pre-edge value. The write becomes visible from the cycle after the edge.
- wr_fire and wr_addr_q:
  - On each edge, wr_fire <= |sel.
  - wr_addr_q <= wa when |sel=1; otherwise wr_addr_q holds.
  - Used for writeback tracing and for the verification monitor.
- Simultaneous events:
  - Read and write of the same address in one cycle are legal and follow the bypass rule.
  - Back-to-back writes to the same address: the last write wins.
- Reset mid-operation:
  - A write whose edge coincides with reset assertion is dropped.
  - The first write after reset deassertion is taken on the first clk edge with reset low.
- Widths: no arithmetic; all address compares are ADDR_W bits, exact match.

Decomposition:
- Shared package (mips_defs):
  - REG_ZERO = 0, REG_RA = 31
  - ADDR_W = 5 default, WIDTH = 32 default
- Sub-module: demux_onehot #(N=2**ADDR_W).
  - Inputs: en, addr.
  - Output: one-hot sel, with bit 0 masked.
  - Pure decoder, reusable by future write-port/CP0 register files.
- Top: register array, read muxing, bypass compare, wr_fire/wr_addr_q flops.

Test Plan:
- Reset state: pulse reset asynchronously mid-cycle, then sweep ra1/ra2 over 0..31.
  - Required: rd1=rd2=0 for every address; wr_fire=0; wr_addr_q=0.
- Basic write/read: write R5=0x12345678 (we=1, wa=5), then set ra1=5 and ra2=6 the next cycle.
  - Required: rd1=0x12345678, rd2=0, wr_fire=1, wr_addr_q=5.
- $zero protection: write wa=0, wd=0xFFFFFFFF, then read ra1=0.
  - Required: rd1=0, wr_fire=0 on the next cycle, wr_addr_q unchanged.
- Bypass: with BYPASS=1, R7 already 0x1, set we=1, wa=7, wd=0xDEADBEEF, ra1=ra2=7 in the same cycle.
  - Required: rd1=rd2=0xDEADBEEF before the edge.
  - Same stimulus with BYPASS=0: rd1=0x1 before the edge, 0xDEADBEEF after.
- Decoder exclusivity: write R31=0xA5A5A5A5 then R30=0x5A5A5A5A on consecutive edges, then read all 32 registers.
  - Required: only R30 and R31 are nonzero, with the exact values written.
- Reset mid-operation: assert reset concurrently with a we=1, wa=9 edge, deassert, then write R9=0x77 on the next edge.
  - Required: R9=0 right after the reset cycle; R9=0x77 after the next edge.
